// File: rtl/data_memory_if.sv
// Bus bundle between the MEM-stage datapath (master) and the data memory (slave).
interface data_memory_if;
  logic        memRead;
  logic        memWrite;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [31:0] readData;

  modport master (
    output memRead,
    output memWrite,
    output address,
    output writeData,
    input  readData
  );

  modport slave (
    input  memRead,
    input  memWrite,
    input  address,
    input  writeData,
    output readData
  );
endinterface

// File: rtl/data_memory.sv
// Word-organised data memory for the RISC-V MEM stage: synchronous word write,
// combinational gated read, synchronous clear on reset.
module data_memory #(
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  data_memory_if.slave  bus
);

  localparam int ADDR_BITS = $clog2(DEPTH);

  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] wordIdx;
  logic                 inRange;
  logic                 unusedByteOffset;

  // Byte offset is dropped: misaligned addresses behave as aligned down.
  assign wordIdx          = bus.address[ADDR_BITS+1:2];
  assign inRange          = (bus.address[31:ADDR_BITS+2] == '0);
  assign unusedByteOffset = ^bus.address[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.memWrite && inRange) begin
      mem[wordIdx] <= bus.writeData;
    end
  end

  always_comb begin
    bus.readData = '0;
    if (bus.memRead && !reset && inRange) begin
      bus.readData = mem[wordIdx];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: array model checked every cycle plus
// directed vectors with hand-computed expected read values.
module tb_data_memory;

  localparam int DEPTH = 256;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  data_memory_if bus ();

  data_memory #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain word array indexed by byte address / 4.
  logic [31:0] model [DEPTH];
  logic        modelInit;

  initial modelInit = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) model[i] <= 32'h0;
      modelInit <= 1'b1;
    end else if (bus.memWrite && (bus.address < 32'(4 * DEPTH))) begin
      model[bus.address / 4] <= bus.writeData;
    end
  end

  function automatic logic [31:0] expectedRead();
    if (reset || !bus.memRead) return 32'h0;
    if (bus.address >= 32'(4 * DEPTH)) return 32'h0;
    return model[bus.address / 4];
  endfunction

  always @(negedge clk) begin
    if (modelInit) begin
      compared++;
      if (bus.readData !== expectedRead()) begin
        mismatched++;
        $display("FAIL cycleCheck t=%0t addr=%h got=%h want=%h",
                 $time, bus.address, bus.readData, expectedRead());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkLit(input string name, input logic [31:0] want);
    #1;
    compared++;
    if (bus.readData !== want) begin
      mismatched++;
      $display("FAIL %s got=%h want=%h", name, bus.readData, want);
    end
  endtask

  task automatic setBus(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd);
    bus.memRead   = rd;
    bus.memWrite  = wr;
    bus.address   = addr;
    bus.writeData = wd;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    setBus(1'b1, 1'b0, 32'h0, 32'h0);
    checkLit("resetOverride", 32'h0);
    tick();
    reset = 1'b0;

    // Cleared memory reads zero
    setBus(1'b1, 1'b0, 32'h0, 32'h0);
    checkLit("postResetAddr0", 32'h0);

    // Basic write then gated read
    setBus(1'b0, 1'b1, 32'h0, 32'hAABBCCDD);
    tick();
    setBus(1'b1, 1'b0, 32'h0, 32'h0);
    checkLit("readAddr0", 32'hAABBCCDD);
    bus.memRead = 1'b0;
    checkLit("readGatedOff", 32'h0);

    // Second word, no aliasing, misaligned read
    setBus(1'b0, 1'b1, 32'h4, 32'h11223344);
    tick();
    setBus(1'b1, 1'b0, 32'h4, 32'h0);
    checkLit("readAddr4", 32'h11223344);
    bus.address = 32'h0;
    checkLit("noAlias", 32'hAABBCCDD);
    bus.address = 32'h6;
    checkLit("misaligned6", 32'h11223344);

    // Out-of-range write ignored, no wrap-around
    setBus(1'b0, 1'b1, 32'(4 * DEPTH), 32'hDEADBEEF);
    tick();
    setBus(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0);
    checkLit("oorRead", 32'h0);
    bus.address = 32'h0;
    checkLit("oorNoWrap", 32'hAABBCCDD);
    bus.address = 32'h8000_0000;
    checkLit("highBitRead", 32'h0);

    // Last word and its misaligned alias
    setBus(1'b0, 1'b1, 32'(4 * (DEPTH - 1)), 32'h12345678);
    tick();
    setBus(1'b1, 1'b0, 32'(4 * (DEPTH - 1)), 32'h0);
    checkLit("lastWord", 32'h12345678);
    bus.address = 32'(4 * DEPTH - 1);
    checkLit("lastWordMisal", 32'h12345678);

    // Simultaneous read and write: old word until the edge
    setBus(1'b1, 1'b1, 32'h8, 32'h5A5A5A5A);
    checkLit("rwBeforeEdge", 32'h0);
    tick();
    checkLit("rwAfterEdge", 32'h5A5A5A5A);
    bus.memWrite = 1'b0;

    // Reset dominates a concurrent write and clears everything
    reset = 1'b1;
    setBus(1'b1, 1'b1, 32'h0, 32'hFFFFFFFF);
    checkLit("resetDuringWrite", 32'h0);
    tick();
    reset = 1'b0;
    setBus(1'b1, 1'b0, 32'h0, 32'h0);
    checkLit("clearedAddr0", 32'h0);
    bus.address = 32'h4;
    checkLit("clearedAddr4", 32'h0);
    bus.address = 32'h8;
    checkLit("clearedAddr8", 32'h0);

    // Few cycles of mixed traffic for the per-cycle model check
    for (int i = 0; i < 8; i++) begin
      setBus(1'b1, i[0], 32'(i * 4), 32'hC0DE_0000 + 32'(i));
      tick();
    end
    setBus(1'b1, 1'b0, 32'h4, 32'h0);
    checkLit("mixedAddr4", 32'hC0DE_0001);
    bus.address = 32'h8;
    checkLit("mixedAddr8NotWritten", 32'h0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
